pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised multi-thread program-counter sequencer for the Arya cores. It holds one PC per hardware thread and issues one instruction fetch address per cycle, choosing threads round-robin. It also accepts branch redirects, stalls and thread masking, and handles the end of the instruction region by wrapping or by faulting. It sits between the core controller and the instruction memory port.

## Interface
Parameters:
- ADDR_WIDTH, 10, PC/instruction-memory address width
- NUM_THREADS, 4, hardware thread contexts (1..16); TID_W = max(1, clog2(NUM_THREADS))
- START_ADDR, 0, reset/wrap value of every PC
- PC_LIMIT, 511, last valid instruction address (START_ADDR <= PC_LIMIT < 2^ADDR_WIDTH)
- STEP, 1, PC increment per issue

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- en  in  1  sequencer enable; 0 = no issue
- stall  in  1  pipeline stall; freezes issue and outputs
- thread_en  in  NUM_THREADS  per-thread run mask
- branch_valid  in  1  redirect request
- branch_tid  in  TID_W  thread being redirected
- branch_target  in  ADDR_WIDTH  new PC for branch_tid
- pc_out  out  ADDR_WIDTH  issued fetch address (registered)
- tid_out  out  TID_W  thread of pc_out
- pc_valid  out  1  pc_out/tid_out valid this cycle
- fault  out  NUM_THREADS  sticky per-thread limit fault (0 when macro absent)

## Operation
- State: pc[t] for each thread, last_tid (last issued thread), output registers.
- Eligible(t) = thread_en[t] & !fault[t].
- Issue when en=1, stall=0 and at least one thread is eligible. The selected thread is the first eligible one in order last_tid+1, last_tid+2, … mod NUM_THREADS, including last_tid itself last.
- On issue: pc_out<=pc[sel], tid_out<=sel, pc_valid<=1, last_tid<=sel, pc[sel]<=next(pc[sel]).
- next(p): if p==PC_LIMIT then wrap behaviour (see Configuration), else (p+STEP) mod 2^ADDR_WIDTH.
- No issue because en=0 or nothing is eligible: pc_valid<=0, pc_out/tid_out hold, last_tid holds, no PC changes.
- stall=1: all outputs hold, including pc_valid. No increment, and last_tid holds.
- Branch: branch_valid=1 writes pc[branch_tid]<=branch_target. This applies regardless of en and stall.
  - Branch priority: a branch beats the increment. If branch_tid==sel in the same cycle, pc_out shows the old PC and pc[sel] becomes branch_target (not target+STEP).
  - Branch fault clear: a branch also clears fault[branch_tid].
- Out-of-range branch_tid (>= NUM_THREADS) is ignored.

## Timing
- Reset values: pc[t]=START_ADDR, last_tid=NUM_THREADS-1, pc_out=0, tid_out=0, pc_valid=0, fault=0. reset overrides branch, en and stall.
- Reset mid-operation: all state returns to the reset values on the next edge; in-flight branches are discarded.
- Issue latency: 1 cycle from the sampled inputs to registered pc_out/pc_valid.
- Back-to-back issue every cycle with no bubble. The first issue after reset is thread 0 at START_ADDR.
- thread_en changes take effect in the selection of the same edge they are sampled on.
- Branch-then-issue: a branch sampled at edge N is visible in pc_out at the earliest at edge N+1 (issue at N+1 shows branch_target).

## Configuration
- PC_LIMIT_FAULT_EN **defined**:
  - Issuing pc==PC_LIMIT still outputs that address.
  - It sets fault[sel]=1 (sticky) and leaves pc[sel]=PC_LIMIT.
  - The thread becomes ineligible until a branch to it or reset.
- PC_LIMIT_FAULT_EN **undefined**:
  - next(PC_LIMIT)=START_ADDR (silent wrap).
  - fault is tied to 0.

## Test plan
- Reset, thread_en=4'b1111, en=1 for 8 cycles -> (tid,pc) = (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1); pc_valid=1 from the first cycle after reset.
- thread_en=4'b0101 -> tids alternate 0,2,0,2. thread_en=0 -> pc_valid=0 and pc_out holds.
- stall=1 for 3 cycles mid-stream -> pc_out, tid_out and pc_valid frozen. On release, the sequence resumes at the next thread with no skipped or repeated PC.
- branch_valid, tid=1, target=0x100 in the same cycle thread 1 issues pc=5 -> pc_out=5 that cycle; the next thread-1 issue shows 0x100, then 0x101.
- Thread 0 branched to 511 (PC_LIMIT):
  - Without macro -> issues 511, then 0.
  - With PC_LIMIT_FAULT_EN -> issues 511, fault[0]=1, and thread 0 is skipped.
  - A later branch tid=0, target=0x20 -> fault[0]=0 and thread 0 issues 0x20.
- Assert reset during continuous issue with a pending branch -> the next cycle shows all outputs at reset values; the first post-reset issue is (0,START_ADDR).

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Multi-thread program-counter sequencer. Holds one PC per hardware thread
// and issues one instruction-fetch address per cycle, picking threads
// round-robin starting after the last issued thread. Branch redirects,
// pipeline stalls and a per-thread run mask are supported. The end of the
// instruction region either wraps silently or raises a sticky per-thread
// fault.
//
// Optional feature macro: PC_LIMIT_FAULT_EN
//   defined   : issuing PC_LIMIT sets a sticky fault[t]; the thread parks at
//               PC_LIMIT and is skipped until a branch to it or reset.
//   undefined : PC_LIMIT wraps to START_ADDR; fault is tied to 0.
//
// Ports:
//   clk            clock, all state on the rising edge
//   reset          synchronous active-high reset
//   en             sequencer enable (0 = no issue)
//   stall          freezes issue, outputs and round-robin pointer
//   thread_en      per-thread run mask
//   branch_valid   redirect request (applies regardless of en/stall)
//   branch_tid     thread being redirected (out-of-range ids ignored)
//   branch_target  new PC for branch_tid
//   pc_out         registered fetch address
//   tid_out        thread of pc_out
//   pc_valid       pc_out/tid_out valid this cycle
//   fault          sticky per-thread limit fault
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_THREADS = 4,
    parameter int START_ADDR  = 0,
    parameter int PC_LIMIT    = 511,
    parameter int STEP        = 1,
    localparam int TID_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   stall,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic                   branch_valid,
    input  logic [TID_W-1:0]       branch_tid,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic [TID_W-1:0]       tid_out,
    output logic                   pc_valid,
    output logic [NUM_THREADS-1:0] fault
);

    localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LIMIT_PC = ADDR_WIDTH'(PC_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] STEP_PC  = ADDR_WIDTH'(STEP);
    localparam logic [TID_W-1:0]      LAST_RST = TID_W'(NUM_THREADS - 1);

    logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] pc_all;
    logic [NUM_THREADS-1:0]                 fault_all;
    logic [NUM_THREADS-1:0]                 eligible;

    logic [TID_W-1:0]      last_tid_q, last_tid_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
    logic [TID_W-1:0]      tid_out_q, tid_out_d;
    logic                  pc_valid_q, pc_valid_d;

    logic [TID_W-1:0]      sel;
    logic                  sel_found;
    logic                  issue;

    assign eligible = thread_en & ~fault_all;

    // Round-robin pick: scan last_tid+1, last_tid+2, ... wrapping, so that
    // last_tid itself is the final candidate.
    always_comb begin
        sel       = last_tid_q;
        sel_found = 1'b0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            int idx;
            idx = (int'(last_tid_q) + k) % NUM_THREADS;
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel       = TID_W'(idx);
            end
        end
    end

    assign issue = en && !stall && sel_found;

    // Per-thread PC and fault state.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
            logic [ADDR_WIDTH-1:0] pc_q, pc_d;
            logic                  issue_here;
            logic                  branch_here;

            assign issue_here  = issue && (sel == TID_W'(gi));
            assign branch_here = branch_valid && (branch_tid == TID_W'(gi));

`ifdef PC_LIMIT_FAULT_EN
            logic fault_q, fault_d;

            always_comb begin
                pc_d    = pc_q;
                fault_d = fault_q;
                if (issue_here) begin
                    if (pc_q == LIMIT_PC) begin
                        // Park at the limit; the thread drops out of selection.
                        fault_d = 1'b1;
                    end else begin
                        pc_d = pc_q + STEP_PC;
                    end
                end
                // A redirect wins over the increment and revives the thread.
                if (branch_here) begin
                    pc_d    = branch_target;
                    fault_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    pc_q    <= START_PC;
                    fault_q <= 1'b0;
                end else begin
                    pc_q    <= pc_d;
                    fault_q <= fault_d;
                end
            end

            assign fault_all[gi] = fault_q;
`else
            always_comb begin
                pc_d = pc_q;
                if (issue_here) begin
                    pc_d = (pc_q == LIMIT_PC) ? START_PC : (pc_q + STEP_PC);
                end
                // A redirect wins over the increment.
                if (branch_here) begin
                    pc_d = branch_target;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    pc_q <= START_PC;
                end else begin
                    pc_q <= pc_d;
                end
            end

            assign fault_all[gi] = 1'b0;
`endif

            assign pc_all[gi] = pc_q;
        end
    endgenerate

    // Output registers and round-robin pointer. A stall freezes everything
    // here, including pc_valid; only branches still update thread PCs.
    always_comb begin
        last_tid_d = last_tid_q;
        pc_out_d   = pc_out_q;
        tid_out_d  = tid_out_q;
        pc_valid_d = pc_valid_q;
        if (!stall) begin
            if (issue) begin
                pc_out_d   = pc_all[sel];
                tid_out_d  = sel;
                pc_valid_d = 1'b1;
                last_tid_d = sel;
            end else begin
                pc_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_tid_q <= LAST_RST;
            pc_out_q   <= '0;
            tid_out_q  <= '0;
            pc_valid_q <= 1'b0;
        end else begin
            last_tid_q <= last_tid_d;
            pc_out_q   <= pc_out_d;
            tid_out_q  <= tid_out_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign pc_out   = pc_out_q;
    assign tid_out  = tid_out_q;
    assign pc_valid = pc_valid_q;
    assign fault    = fault_all;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed self-checking bench for pc_sequencer with default parameters
// (ADDR_WIDTH=10, NUM_THREADS=4, START_ADDR=0, PC_LIMIT=511, STEP=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, after the edge they were registered on. Expected values are
// hand-derived and written inline next to each step.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       stall;
    logic [3:0] thread_en;
    logic       branch_valid;
    logic [1:0] branch_tid;
    logic [9:0] branch_target;
    logic [9:0] pc_out;
    logic [1:0] tid_out;
    logic       pc_valid;
    logic [3:0] fault;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .stall         (stall),
        .thread_en     (thread_en),
        .branch_valid  (branch_valid),
        .branch_tid    (branch_tid),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .tid_out       (tid_out),
        .pc_valid      (pc_valid),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One clock, then check an issued (tid, pc) pair.
    task automatic exp_issue(input string tag, input int t, input int p);
        step();
        $display("[%0t] %s: valid=%0d tid=%0d pc=0x%0h (expect 1/%0d/0x%0h)",
                 $time, tag, pc_valid, tid_out, pc_out, t, p);
        chk({tag, ".valid"}, int'(pc_valid), 1);
        chk({tag, ".tid"},   int'(tid_out),  t);
        chk({tag, ".pc"},    int'(pc_out),   p);
    endtask

    // One clock, then check outputs with an explicit valid value.
    task automatic exp_out(input string tag, input int v, input int t, input int p);
        step();
        $display("[%0t] %s: valid=%0d tid=%0d pc=0x%0h (expect %0d/%0d/0x%0h)",
                 $time, tag, pc_valid, tid_out, pc_out, v, t, p);
        chk({tag, ".valid"}, int'(pc_valid), v);
        chk({tag, ".tid"},   int'(tid_out),  t);
        chk({tag, ".pc"},    int'(pc_out),   p);
    endtask

    initial begin
        reset         = 1'b1;
        en            = 1'b0;
        stall         = 1'b0;
        thread_en     = 4'b1111;
        branch_valid  = 1'b0;
        branch_tid    = 2'd0;
        branch_target = 10'd0;

        // Reset state
        step();
        exp_out("reset", 0, 0, 0);
        chk("reset.fault", int'(fault), 0);

        // Full round-robin over all four threads
        reset = 1'b0;
        en    = 1'b1;
        exp_issue("rr0", 0, 0);
        exp_issue("rr1", 1, 0);
        exp_issue("rr2", 2, 0);
        exp_issue("rr3", 3, 0);
        exp_issue("rr4", 0, 1);
        exp_issue("rr5", 1, 1);
        exp_issue("rr6", 2, 1);
        exp_issue("rr7", 3, 1);
        // PCs now t0..t3 = 2, last_tid = 3

        // Mask to threads 0 and 2
        thread_en = 4'b0101;
        exp_issue("mask0", 0, 2);
        exp_issue("mask1", 2, 2);
        exp_issue("mask2", 0, 3);
        exp_issue("mask3", 2, 3);
        // t0=4 t1=2 t2=4 t3=2, last_tid=2

        // No eligible thread: valid drops, outputs hold
        thread_en = 4'b0000;
        exp_out("none", 0, 2, 3);

        // Re-enable: selection continues after thread 2
        thread_en = 4'b1111;
        exp_issue("resume", 3, 2);
        // t3=3, last_tid=3

        // Stall for three cycles: everything frozen
        stall = 1'b1;
        exp_out("stall0", 1, 3, 2);
        exp_out("stall1", 1, 3, 2);
        exp_out("stall2", 1, 3, 2);
        stall = 1'b0;
        exp_issue("post_stall0", 0, 4);
        exp_issue("post_stall1", 1, 2);
        exp_issue("post_stall2", 2, 4);
        exp_issue("post_stall3", 3, 3);
        // t0=5 t1=3 t2=5 t3=4, last_tid=3

        // Branch while disabled still lands: thread 1 -> 5
        en            = 1'b0;
        branch_valid  = 1'b1;
        branch_tid    = 2'd1;
        branch_target = 10'd5;
        exp_out("br_idle", 0, 3, 3);
        branch_valid = 1'b0;
        en           = 1'b1;
        exp_issue("br_a", 0, 5);
        // Branch to thread 1 in the same cycle thread 1 issues pc=5
        branch_valid  = 1'b1;
        branch_tid    = 2'd1;
        branch_target = 10'h100;
        exp_issue("br_same", 1, 5);
        branch_valid = 1'b0;
        exp_issue("br_b", 2, 5);
        exp_issue("br_c", 3, 4);
        exp_issue("br_d", 0, 6);
        exp_issue("br_tgt", 1, 'h100);
        exp_issue("br_e", 2, 6);
        exp_issue("br_f", 3, 5);
        exp_issue("br_g", 0, 7);
        exp_issue("br_tgt1", 1, 'h101);
        // last_tid=1

        // End of region on thread 0 alone
        thread_en     = 4'b0001;
        en            = 1'b0;
        branch_valid  = 1'b1;
        branch_tid    = 2'd0;
        branch_target = 10'd511;
        exp_out("lim_br", 0, 1, 'h101);
        branch_valid = 1'b0;
        en           = 1'b1;
        exp_issue("lim_issue", 0, 511);
`ifdef PC_LIMIT_FAULT_EN
        chk("lim.fault_set", int'(fault), 1);
        exp_out("lim_skip", 0, 0, 511);
        chk("lim.fault_hold", int'(fault), 1);
        en            = 1'b0;
        branch_valid  = 1'b1;
        branch_tid    = 2'd0;
        branch_target = 10'h20;
        exp_out("lim_clr", 0, 0, 511);
        chk("lim.fault_clr", int'(fault), 0);
`else
        exp_issue("lim_wrap", 0, 0);
        chk("lim.fault_zero", int'(fault), 0);
        en            = 1'b0;
        branch_valid  = 1'b1;
        branch_tid    = 2'd0;
        branch_target = 10'h20;
        exp_out("lim_clr", 0, 0, 0);
        chk("lim.fault_clr", int'(fault), 0);
`endif
        branch_valid = 1'b0;
        en           = 1'b1;
        exp_issue("lim_after", 0, 'h20);

        // Reset during issue with a pending branch: branch discarded
        thread_en     = 4'b1111;
        branch_valid  = 1'b1;
        branch_tid    = 2'd2;
        branch_target = 10'h55;
        reset         = 1'b1;
        exp_out("mid_reset", 0, 0, 0);
        chk("mid_reset.fault", int'(fault), 0);
        reset        = 1'b0;
        branch_valid = 1'b0;
        exp_issue("post_rst0", 0, 0);
        exp_issue("post_rst1", 1, 0);
        exp_issue("post_rst2", 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
